parking_gate_arbiter: RTL

Shares the single parking-lot door between one entry requester and four per-slot exit requesters. Each accepted request moves through one gate cycle: grant, door open for a fixed time, then a closed guard gap. The block owns the slot occupancy bitmap and allocates the lowest free slot to each entering car. It sits between the gate sensors/buttons and the display/LED logic, which consume `occupancy`, `full` and `door_open`.

---
 rtl/parking_pkg.sv | 33 +++
 rtl/gate_door_timer.sv | 72 +++++++
 rtl/parking_gate_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared constants, gate state type and slot-allocation helper for the parking gate arbiter.
package parking_pkg;

    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned NUM_REQ   = 5;

    localparam int unsigned REQ_ENTRY = 0;
    localparam int unsigned REQ_EXIT0 = 1;
    localparam int unsigned REQ_EXIT1 = 2;
    localparam int unsigned REQ_EXIT2 = 3;
    localparam int unsigned REQ_EXIT3 = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        OPEN  = 2'd2,
        GAP   = 2'd3
    } gate_state_t;

    // Lowest-index clear bit; callers only use it when at least one slot is free.
    function automatic logic [1:0] lowest_free(input logic [NUM_SLOTS-1:0] occ);
        logic found;
        lowest_free = '0;
        found       = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!found && !occ[i]) begin
                lowest_free = 2'(i);
                found       = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/gate_door_timer.sv
// Door timing for one gate cycle: door open for DOOR_CYCLES, then closed for MIN_GAP,
// with open_end marking the last open cycle and done marking the last gap cycle.
module gate_door_timer
    import parking_pkg::*;
#(
    parameter int DOOR_CYCLES = 6,
    parameter int MIN_GAP     = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    output logic door_open,
    output logic open_end,
    output logic done
);

    localparam int MAX_CYC = (DOOR_CYCLES > MIN_GAP) ? DOOR_CYCLES : MIN_GAP;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    gate_state_t      phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             door_open_q, door_open_d;

    always_comb begin
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        open_end    = 1'b0;
        done        = 1'b0;
        // Registered door output trails the open phase by one cycle.
        door_open_d = (phase_q == OPEN);
        case (phase_q)
            OPEN: begin
                if (cnt_q == '0) begin
                    open_end = 1'b1;
                    phase_d  = GAP;
                    cnt_d    = CNT_W'(MIN_GAP - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    phase_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                if (start) begin
                    phase_d = OPEN;
                    cnt_d   = CNT_W'(DOOR_CYCLES - 1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q     <= IDLE;
            cnt_q       <= '0;
            door_open_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            door_open_q <= door_open_d;
        end
    end

    assign door_open = door_open_q;

endmodule

// File: rtl/parking_gate_arbiter.sv
// Arbitrates the single parking door between the entry and four slot exits and owns occupancy.
// Define PARK_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority exit0..exit3 > entry.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int DOOR_CYCLES = 6,
    parameter int MIN_GAP     = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 entry_req,
    input  logic [NUM_SLOTS-1:0] exit_req,
    output logic                 entry_ack,
    output logic [NUM_SLOTS-1:0] exit_ack,
    output logic [1:0]           slot_assigned,
    output logic                 door_open,
    output logic [NUM_SLOTS-1:0] occupancy,
    output logic                 full,
    output logic                 busy
);

    gate_state_t          state_q, state_d;
    logic [2:0]           winner_q, winner_d;
    logic [NUM_SLOTS-1:0] occ_q, occ_d;
    logic                 entry_ack_q, entry_ack_d;
    logic [NUM_SLOTS-1:0] exit_ack_q, exit_ack_d;
    logic [1:0]           slot_q, slot_d;
`ifdef PARK_ARB_ROUND_ROBIN_EN
    logic [2:0]           ptr_q, ptr_d;
`endif

    logic [NUM_REQ-1:0]   elig;
    logic                 found;
    logic [2:0]           pick;
    logic [1:0]           free_idx;
    logic [1:0]           exit_idx;
    logic                 start;
    logic                 open_end;
    logic                 timer_done;

    assign full     = &occ_q;
    assign elig     = {exit_req & occ_q, entry_req && !full};
    assign free_idx = lowest_free(occ_q);
    assign exit_idx = 2'(winner_q - 3'd1);
    assign start    = (state_q == GRANT);

    always_comb begin
        found = 1'b0;
        pick  = '0;
`ifdef PARK_ARB_ROUND_ROBIN_EN
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            int unsigned idx;
            idx = (32'(ptr_q) + k) % NUM_REQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = 3'(idx);
            end
        end
`else
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if (!found && elig[REQ_EXIT0 + k]) begin
                found = 1'b1;
                pick  = 3'(REQ_EXIT0 + k);
            end
        end
        if (!found && elig[REQ_ENTRY]) begin
            found = 1'b1;
            pick  = 3'(REQ_ENTRY);
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        occ_d       = occ_q;
        entry_ack_d = 1'b0;
        exit_ack_d  = '0;
        slot_d      = '0;
`ifdef PARK_ARB_ROUND_ROBIN_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    winner_d = pick;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                // Acks and occupancy are registered here so they appear one cycle after the grant decision.
                if (winner_q == 3'(REQ_ENTRY)) begin
                    entry_ack_d     = 1'b1;
                    slot_d          = free_idx;
                    occ_d[free_idx] = 1'b1;
                end else begin
                    exit_ack_d[exit_idx] = 1'b1;
                    occ_d[exit_idx]      = 1'b0;
                end
`ifdef PARK_ARB_ROUND_ROBIN_EN
                ptr_d   = winner_q;
`endif
                state_d = OPEN;
            end
            OPEN: begin
                if (open_end) state_d = GAP;
            end
            GAP: begin
                if (timer_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            winner_q    <= '0;
            occ_q       <= '0;
            entry_ack_q <= 1'b0;
            exit_ack_q  <= '0;
            slot_q      <= '0;
`ifdef PARK_ARB_ROUND_ROBIN_EN
            ptr_q       <= 3'(REQ_EXIT3);
`endif
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            occ_q       <= occ_d;
            entry_ack_q <= entry_ack_d;
            exit_ack_q  <= exit_ack_d;
            slot_q      <= slot_d;
`ifdef PARK_ARB_ROUND_ROBIN_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    gate_door_timer #(
        .DOOR_CYCLES (DOOR_CYCLES),
        .MIN_GAP     (MIN_GAP)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .door_open (door_open),
        .open_end  (open_end),
        .done      (timer_done)
    );

    assign entry_ack     = entry_ack_q;
    assign exit_ack      = exit_ack_q;
    assign slot_assigned = slot_q;
    assign occupancy     = occ_q;
    assign busy          = (state_q != IDLE);

endmodule
